wport_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one register-file write port between 4 requesters.
//  - Winner index is registered and one-hot decoded (2-to-4, enable = grant valid) into gnt.
//  - A dead cycle is enforced between owners (port turnaround).
//  - An optional hold limit stops any requester from monopolising the port.

---
 rtl/wport_rr_arbiter.sv | 105 ++++++++++
 tb/tb_wport_rr_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wport_rr_arbiter.sv
// wport_rr_arbiter: round-robin owner selection for a shared register-file
// write port across 4 requesters. It enforces a one-cycle turnaround between
// owners and can optionally limit how long one owner holds the port.
module wport_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8   // 0 = unlimited, legal 0..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_e;

    localparam bit         HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(HOLD_MAX - 1) : 8'd0;

    state_e     state_q;
    logic [3:0] gnt_q;
    logic [1:0] gnt_idx_q;
    logic       gnt_valid_q;
    logic       timeout_q;
    logic [1:0] last_q;
    logic [7:0] hold_cnt_q;

    logic [1:0] win;
    logic [1:0] cand;
    logic       found;

    // Round-robin search starting just after the last owner and wrapping upward
    always_comb begin
        win   = last_q;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // Ownership FSM; every output is registered and the winner index is decoded into gnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= 2'd3;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            last_q      <= 2'd3;
            hold_cnt_q  <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE, TURN: begin
                    if (|req) begin
                        state_q     <= GRANT;
                        gnt_idx_q   <= win;
                        last_q      <= win;
                        gnt_q       <= 4'(4'b0001 << win);
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    // A dropping owner takes precedence over the hold limit, so no timeout then
                    if (!req[gnt_idx_q]) begin
                        state_q     <= TURN;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                    end else if (HOLD_EN && (hold_cnt_q == HOLD_LAST)) begin
                        state_q     <= TURN;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        timeout_q   <= 1'b1;
                    end else if (hold_cnt_q != 8'hFF) begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_q       <= '0;
                    gnt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_wport_rr_arbiter.sv
// Self-checking bench for wport_rr_arbiter: four instances with different
// hold limits share one request bus and are compared against a behavioural model.
module tb_wport_rr_arbiter;

    localparam int NI = 4;
    localparam int HM [NI] = '{8, 4, 1, 0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'hF;

    logic [3:0] gnt_a   [NI];
    logic [1:0] idx_a   [NI];
    logic       valid_a [NI];
    logic       to_a    [NI];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: owner (-1 = none), last winner, cycles already held, timeout flag
    int m_owner [NI];
    int m_last  [NI];
    int m_held  [NI];
    int m_to    [NI];

    always #5 clk = ~clk;

    wport_rr_arbiter #(.HOLD_MAX(8)) u_h8 (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_a[0]),
        .gnt_idx(idx_a[0]), .gnt_valid(valid_a[0]), .timeout(to_a[0]));
    wport_rr_arbiter #(.HOLD_MAX(4)) u_h4 (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_a[1]),
        .gnt_idx(idx_a[1]), .gnt_valid(valid_a[1]), .timeout(to_a[1]));
    wport_rr_arbiter #(.HOLD_MAX(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_a[2]),
        .gnt_idx(idx_a[2]), .gnt_valid(valid_a[2]), .timeout(to_a[2]));
    wport_rr_arbiter #(.HOLD_MAX(0)) u_h0 (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_a[3]),
        .gnt_idx(idx_a[3]), .gnt_valid(valid_a[3]), .timeout(to_a[3]));

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t tv [18];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_owner[i] = -1;
            m_last[i]  = 3;
            m_held[i]  = 0;
            m_to[i]    = 0;
        end
    endtask

    // One clock edge of the arbitration rules, using the request vector seen at that edge
    task automatic model_step(input logic [3:0] r);
        for (int i = 0; i < NI; i++) begin
            if (m_owner[i] >= 0) begin
                if (!r[m_owner[i]]) begin
                    m_owner[i] = -1;
                    m_to[i]    = 0;
                end else if (HM[i] != 0 && m_held[i] + 1 == HM[i]) begin
                    m_owner[i] = -1;
                    m_to[i]    = 1;
                end else begin
                    m_held[i]++;
                    m_to[i] = 0;
                end
            end else begin
                m_to[i] = 0;
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_last[i] + k) % 4;
                    if (m_owner[i] < 0 && r[c]) begin
                        m_owner[i] = c;
                        m_last[i]  = c;
                        m_held[i]  = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < NI; i++) begin
            int eg;
            eg = (m_owner[i] >= 0) ? (1 << m_owner[i]) : 0;
            chk($sformatf("gnt[h%0d]", HM[i]), int'(gnt_a[i]), eg);
            chk($sformatf("idx[h%0d]", HM[i]), int'(idx_a[i]), m_last[i]);
            chk($sformatf("valid[h%0d]", HM[i]), int'(valid_a[i]), (m_owner[i] >= 0) ? 1 : 0);
            chk($sformatf("timeout[h%0d]", HM[i]), int'(to_a[i]), m_to[i]);
        end
    endtask

    task automatic tick();
        model_step(req);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g,
                                input logic [1:0] x, input logic v);
        vec_t t;
        t.req = r; t.gnt = g; t.idx = x; t.valid = v; t.to = 1'b0;
        return t;
    endfunction

    initial begin
        // Single owner held 3 cycles, then released (rows 0..4); full rotation (rows 5..17, after reset)
        tv[0]  = mk(4'b0100, 4'b0100, 2'd2, 1'b1);
        tv[1]  = mk(4'b0100, 4'b0100, 2'd2, 1'b1);
        tv[2]  = mk(4'b0100, 4'b0100, 2'd2, 1'b1);
        tv[3]  = mk(4'b0000, 4'b0000, 2'd2, 1'b0);
        tv[4]  = mk(4'b0000, 4'b0000, 2'd2, 1'b0);
        tv[5]  = mk(4'hF,    4'b0001, 2'd0, 1'b1);
        tv[6]  = mk(4'hF,    4'b0001, 2'd0, 1'b1);
        tv[7]  = mk(4'hE,    4'b0000, 2'd0, 1'b0);
        tv[8]  = mk(4'hF,    4'b0010, 2'd1, 1'b1);
        tv[9]  = mk(4'hF,    4'b0010, 2'd1, 1'b1);
        tv[10] = mk(4'hD,    4'b0000, 2'd1, 1'b0);
        tv[11] = mk(4'hF,    4'b0100, 2'd2, 1'b1);
        tv[12] = mk(4'hF,    4'b0100, 2'd2, 1'b1);
        tv[13] = mk(4'hB,    4'b0000, 2'd2, 1'b0);
        tv[14] = mk(4'hF,    4'b1000, 2'd3, 1'b1);
        tv[15] = mk(4'hF,    4'b1000, 2'd3, 1'b1);
        tv[16] = mk(4'h7,    4'b0000, 2'd3, 1'b0);
        tv[17] = mk(4'hF,    4'b0001, 2'd0, 1'b1);

        // Reset held with all requests asserted: outputs stay at reset values
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("rst_gnt", int'(gnt_a[0]), 0);
            chk("rst_valid", int'(valid_a[0]), 0);
            chk("rst_idx", int'(idx_a[0]), 3);
            chk("rst_timeout", int'(to_a[0]), 0);
        end
        check_model();
        req = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors against the HOLD_MAX=8 instance
        for (int v = 0; v < 18; v++) begin
            if (v == 5) do_reset();
            req = tv[v].req;
            tick();
            chk($sformatf("tv%0d_gnt", v), int'(gnt_a[0]), int'(tv[v].gnt));
            chk($sformatf("tv%0d_idx", v), int'(idx_a[0]), int'(tv[v].idx));
            chk($sformatf("tv%0d_valid", v), int'(valid_a[0]), int'(tv[v].valid));
            chk($sformatf("tv%0d_to", v), int'(to_a[0]), int'(tv[v].to));
        end

        // HOLD_MAX=4 with two requesters held: alternating 4-cycle grants with timeout gaps
        req = 4'h0;
        do_reset();
        req = 4'b0011;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk("h4_hold_gnt", int'(gnt_a[1]), (r % 2 == 0) ? 1 : 2);
                chk("h4_hold_to", int'(to_a[1]), 0);
            end
            tick();
            chk("h4_gap_gnt", int'(gnt_a[1]), 0);
            chk("h4_gap_to", int'(to_a[1]), 1);
        end

        // HOLD_MAX=4, owner drops in its 4th grant cycle: plain release, no timeout
        req = 4'h0;
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 4; c++) tick();
        chk("h4_last_gnt", int'(gnt_a[1]), 1);
        req = 4'b0000;
        tick();
        chk("h4_drop_gnt", int'(gnt_a[1]), 0);
        chk("h4_drop_to", int'(to_a[1]), 0);

        // Asynchronous reset while requester 3 owns the port; priority restarts at 0
        req = 4'h0;
        do_reset();
        req = 4'b1000;
        tick();
        chk("pre_async_gnt", int'(gnt_a[0]), 8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_gnt", int'(gnt_a[0]), 0);
        chk("async_valid", int'(valid_a[0]), 0);
        chk("async_idx", int'(idx_a[0]), 3);
        model_reset();
        req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_async_gnt", int'(gnt_a[0]), 1);

        // Randomized request traffic against the model for all hold limits
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] flip;
            for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 5) == 0);
            req = req ^ flip;
            tick();
            for (int i = 0; i < NI; i++) begin
                chk("onehot", int'($countones(gnt_a[i]) <= 1), 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
